// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//   Definitions shared by the line-fill engine and the tag/data-array logic.
//   - CACHE_LINE_WORDS / CACHE_OFFSET_WIDTH : default line geometry
//   - word_t                                : one cache word / bus beat
//   - refill_state_t                        : line-fill FSM states
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int CACHE_LINE_WORDS   = 8;
  localparam int CACHE_OFFSET_WIDTH = $clog2(CACHE_LINE_WORDS);
  localparam int CACHE_WORD_WIDTH   = 32;

  typedef logic [CACHE_WORD_WIDTH-1:0] word_t;

  // Encodings are kept as plain constants as well, so that older blocks
  // which compare against raw state codes stay compatible.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    DATA = ST_DATA,
    DONE = ST_DONE
  } refill_state_t;

endpackage

// File: rtl/cache_line_refill.sv
// -----------------------------------------------------------------------------
// cache_line_refill
//   Line-fill engine for the cache data array. Accepts one line request,
//   issues a single incrementing burst read, writes every returned beat
//   directly into the BRAM write port, forwards the missed word to the core,
//   and pulses done when the line is complete.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/ready     refill request handshake, req_addr = missed byte address
//   ar_valid/ready      burst read address channel (ar_addr line base, ar_len)
//   r_valid/ready       read data channel (r_data, r_last)
//   bram_*              BRAM write port (enable, byte enables, word address, data)
//   resp_valid/data     one-cycle pulse carrying the missed word
//   busy                block owns the BRAM port (ADDR/DATA/DONE)
//   done, err           one-cycle completion pulse; err flags an r_last mismatch
// -----------------------------------------------------------------------------
module cache_line_refill
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_WORDS      = CACHE_LINE_WORDS,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  output logic                       ar_valid,
  input  logic                       ar_ready,
  output logic [ADDR_WIDTH-1:0]      ar_addr,
  output logic [7:0]                 ar_len,
  input  logic                       r_valid,
  output logic                       r_ready,
  input  logic [DATA_WIDTH-1:0]      r_data,
  input  logic                       r_last,
  output logic                       bram_en,
  output logic [DATA_WIDTH/8-1:0]    bram_write_en,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_data_in,
  output logic                       resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int SET_W = BRAM_ADDR_WIDTH - OFF_W;
  localparam int TAG_W = ADDR_WIDTH - BYTE_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_COUNT = OFF_W'(LINE_WORDS - 1);

  refill_state_t    state;
  logic [OFF_W-1:0] count;
  logic [TAG_W-1:0] line_q;
  logic [OFF_W-1:0] offset_q;
  logic             err_q;
  logic             beat;
  logic             line_end;
  logic             unused_byte_bits;

  // Byte-within-word bits of the request never matter: the engine always
  // moves whole words.
  assign unused_byte_bits = &{1'b0, req_addr[BYTE_W-1:0]};

  // A beat is a read transfer actually taken this cycle. The line finishes on
  // the last counted word or on an early r_last, whichever comes first, so a
  // misbehaving bus can never push the count past the line.
  assign beat     = (state == DATA) && r_valid;
  assign line_end = beat && ((count == LAST_COUNT) || r_last);

  // Channel handshakes and status are pure decodes of the state, so they fall
  // to their idle values the moment reset hits.
  assign req_ready = (state == IDLE);
  assign ar_valid  = (state == ADDR);
  assign ar_addr   = ar_valid ? {line_q, {(BYTE_W + OFF_W){1'b0}}} : '0;
  assign ar_len    = ar_valid ? 8'(LINE_WORDS - 1) : 8'd0;
  assign r_ready   = (state == DATA);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = done && err_q;

  // Each beat is written straight through to the BRAM in the same cycle it
  // arrives; the word lands at the clock edge that also advances the count.
  // The missed word is forwarded to the core when its offset comes past.
  assign bram_en       = beat;
  assign bram_write_en = {(DATA_WIDTH / 8){beat}};
  assign bram_addr     = beat ? {line_q[SET_W-1:0], count} : '0;
  assign bram_data_in  = beat ? r_data : '0;
  assign resp_valid    = beat && (count == offset_q);
  assign resp_data     = resp_valid ? r_data : '0;

  // Refill sequencer. The request address is captured once on accept and held
  // for the whole line, which keeps ar_addr stable while waiting for ar_ready.
  // A reset mid-burst simply drops the line; the tag logic must not mark it
  // valid because done never pulses for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      line_q   <= '0;
      offset_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_q   <= req_addr[ADDR_WIDTH-1:BYTE_W+OFF_W];
            offset_q <= req_addr[BYTE_W +: OFF_W];
            count    <= '0;
            err_q    <= 1'b0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (ar_ready) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (line_end) begin
            err_q <= (r_last != (count == LAST_COUNT));
            state <= DONE;
          end else if (beat) begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_refill.sv
// -----------------------------------------------------------------------------
// tb_cache_line_refill
//   Directed bench for the line-fill engine: a table of refill scenarios with
//   hand-computed results, plus hand-written sequences for reset mid-burst and
//   back-to-back requests. A small BRAM model stands in for the data array.
// -----------------------------------------------------------------------------
module tb_cache_line_refill;

  localparam logic [31:0] MARK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_last;
  logic        bram_en;
  logic [3:0]  bram_write_en;
  logic [9:0]  bram_addr;
  logic [31:0] bram_data_in;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        busy;
  logic        done;
  logic        err;

  int num_checks = 0;
  int num_errors = 0;

  cache_line_refill dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .ar_valid     (ar_valid),
    .ar_ready     (ar_ready),
    .ar_addr      (ar_addr),
    .ar_len       (ar_len),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .r_last       (r_last),
    .bram_en      (bram_en),
    .bram_write_en(bram_write_en),
    .bram_addr    (bram_addr),
    .bram_data_in (bram_data_in),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // BRAM model: every write is stamped with the current run number so a
  // check can tell "written in this run" apart from stale contents.
  logic [31:0] mem   [0:1023];
  int          stamp [0:1023];
  int          run_id = 0;

  always @(posedge clk) begin
    if (bram_en && bram_write_en == 4'hF) begin
      mem[bram_addr]   <= bram_data_in;
      stamp[bram_addr] <= run_id;
    end
  end

  // Mid-cycle monitor: events are sampled at the falling edge and become
  // effective at the next rising edge. Counters only ever grow; tests take
  // snapshots and compare differences.
  int          cyc = 0;
  int          write_count = 0;
  int          last_write_cyc = 0;
  int          gap_viol = 0;
  int          stab_viol = 0;
  int          resp_count = 0;
  logic [31:0] resp_seen = '0;
  logic        resp_last_seen = 1'b0;
  int          done_count = 0;
  int          done_cyc = 0;
  logic        err_seen = 1'b0;
  int          accept_count = 0;
  int          accept_cyc = 0;
  logic [31:0] ar_addr_seen = '0;
  logic [7:0]  ar_len_seen = '0;
  logic        ar_pending = 1'b0;
  logic        ar_valid_prev = 1'b0;
  logic [31:0] ar_addr_prev = '0;
  logic [7:0]  ar_len_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_en) begin
      write_count++;
      last_write_cyc = cyc;
      if (!r_valid || bram_write_en != 4'hF) gap_viol++;
    end
    if (resp_valid) begin
      resp_count++;
      resp_seen      = resp_data;
      resp_last_seen = r_last;
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
      err_seen = err;
    end
    if (req_valid && req_ready) begin
      accept_count++;
      accept_cyc = cyc;
    end
    if (ar_pending && (!ar_valid || ar_addr != ar_addr_prev || ar_len != ar_len_prev))
      stab_viol++;
    if (ar_valid && !ar_valid_prev) begin
      ar_addr_seen = ar_addr;
      ar_len_seen  = ar_len;
    end
    ar_pending    = ar_valid && !ar_ready;
    ar_valid_prev = ar_valid;
    ar_addr_prev  = ar_addr;
    ar_len_prev   = ar_len;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one refill from IDLE: request, optional ar_ready stall, then beats
  // (0x11, 0x22, ...) either back-to-back or on every other cycle. r_last is
  // raised on beat last_at; the burst ends on that beat, on beat 7, or after
  // stop_beats beats. Returns just after the edge that took the final beat.
  task automatic apply_stimulus(input logic [31:0] addr, input int ar_wait, input bit gap,
                                input int last_at, input int stop_beats, input bit hold_req);
    int cycles;
    int beat;
    bit fin;
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    check_output("req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = hold_req;
    fin = 1'b0;
    cycles = 0;
    while (!fin && cycles < 50) begin
      ar_ready = (cycles >= ar_wait);
      @(negedge clk);
      if (ar_valid && ar_ready) fin = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    ar_ready = 1'b0;
    check_output("ar_handshake", 64'(fin), 64'd1);
    fin = 1'b0;
    cycles = 0;
    beat = 0;
    while (!fin && cycles < 100) begin
      r_valid = gap ? cycles[0] : 1'b1;
      r_data  = 32'((beat + 1) * 32'h11);
      r_last  = (beat == last_at);
      @(negedge clk);
      if (r_valid && r_ready) begin
        if (beat == last_at || beat == 7 || beat + 1 == stop_beats) fin = 1'b1;
        beat++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_data  = '0;
    check_output("data_phase", 64'(fin), 64'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          ar_wait;
    bit          gap;
    int          last_at;
    logic [31:0] exp_ar_addr;
    logic [9:0]  exp_base;
    int          exp_writes;
    int          exp_resp_count;
    logic [31:0] exp_resp_data;
    bit          exp_resp_last;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  int          base_writes, base_resp, base_done, base_accept, base_gap, base_stab;
  int          first_done;
  logic [9:0]  a;
  logic [31:0] act_word, exp_word;

  initial begin
    // addr, ar_wait, gap, last_at, ar_addr, bram base, writes, resps, resp data, resp on last, err
    vecs[0] = '{32'h0000_0104, 0, 1'b0, 7, 32'h0000_0100, 10'h040, 8, 1, 32'h22, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_02A8, 5, 1'b1, 7, 32'h0000_02A0, 10'h0A8, 8, 1, 32'h33, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_011C, 0, 1'b0, 7, 32'h0000_0100, 10'h040, 8, 1, 32'h88, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0104, 0, 1'b0, 3, 32'h0000_0100, 10'h040, 4, 1, 32'h22, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0314, 0, 1'b0, 3, 32'h0000_0300, 10'h0C0, 4, 0, 32'h00, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_03F8, 0, 1'b1, 8, 32'h0000_03E0, 10'h0F8, 8, 1, 32'h77, 1'b0, 1'b1};
    vecs[6] = '{32'h1234_5678, 2, 1'b0, 7, 32'h1234_5660, 10'h198, 8, 1, 32'h77, 1'b0, 1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_last    = 1'b0;

    repeat (5) @(negedge clk);
    check_output("reset_req_ready", 64'(req_ready), 64'd1);
    check_output("reset_outputs", 64'(|{ar_valid, ar_addr, ar_len, r_ready, bram_en, bram_write_en,
                 bram_addr, bram_data_in, resp_valid, resp_data, busy, done, err}), 64'd0);
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven refills.
    for (int v = 0; v < 7; v++) begin
      run_id++;
      base_writes = write_count;
      base_resp   = resp_count;
      base_done   = done_count;
      base_gap    = gap_viol;
      base_stab   = stab_viol;
      apply_stimulus(vecs[v].addr, vecs[v].ar_wait, vecs[v].gap, vecs[v].last_at, 99, 1'b0);
      @(posedge clk); #1;
      check_output("ar_addr", 64'(ar_addr_seen), 64'(vecs[v].exp_ar_addr));
      check_output("ar_len", 64'(ar_len_seen), 64'd7);
      check_output("ar_stable", 64'(stab_viol - base_stab), 64'd0);
      check_output("write_gating", 64'(gap_viol - base_gap), 64'd0);
      check_output("write_count", 64'(write_count - base_writes), 64'(vecs[v].exp_writes));
      check_output("resp_count", 64'(resp_count - base_resp), 64'(vecs[v].exp_resp_count));
      if (vecs[v].exp_resp_count > 0) begin
        check_output("resp_data", 64'(resp_seen), 64'(vecs[v].exp_resp_data));
        check_output("resp_with_last", 64'(resp_last_seen), 64'(vecs[v].exp_resp_last));
      end
      check_output("done_count", 64'(done_count - base_done), 64'd1);
      check_output("done_timing", 64'(done_cyc - last_write_cyc), 64'd1);
      check_output("err", 64'(err_seen), 64'(vecs[v].exp_err));
      for (int i = 0; i < 8; i++) begin
        a        = vecs[v].exp_base + 10'(i);
        act_word = (stamp[a] == run_id) ? mem[a] : MARK;
        exp_word = (i < vecs[v].exp_writes) ? 32'((i + 1) * 32'h11) : MARK;
        check_output("bram_word", 64'(act_word), 64'(exp_word));
      end
    end

    // Reset after beat 2: the line is abandoned immediately and the engine
    // ignores a bus that keeps offering data.
    run_id++;
    base_writes = write_count;
    base_done   = done_count;
    apply_stimulus(32'h0000_0104, 0, 1'b0, 99, 3, 1'b0);
    r_valid = 1'b1;
    r_data  = 32'h44;
    reset   = 1'b1;
    @(negedge clk);
    check_output("rst_mid_req_ready", 64'(req_ready), 64'd1);
    check_output("rst_mid_outputs", 64'(|{ar_valid, r_ready, bram_en, bram_write_en, resp_valid,
                 busy, done, err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_after_r_ready", 64'(r_ready), 64'd0);
    check_output("rst_after_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    r_valid = 1'b0;
    check_output("rst_write_count", 64'(write_count - base_writes), 64'd3);
    check_output("rst_no_done", 64'(done_count - base_done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      a        = 10'h040 + 10'(i);
      act_word = (stamp[a] == run_id) ? mem[a] : MARK;
      exp_word = (i < 3) ? 32'((i + 1) * 32'h11) : MARK;
      check_output("rst_bram_word", 64'(act_word), 64'(exp_word));
    end

    // Fresh request after the reset completes normally.
    run_id++;
    base_done = done_count;
    apply_stimulus(32'h0000_0104, 0, 1'b0, 7, 99, 1'b0);
    @(posedge clk); #1;
    check_output("fresh_done", 64'(done_count - base_done), 64'd1);
    check_output("fresh_err", 64'(err_seen), 64'd0);
    check_output("fresh_resp", 64'(resp_seen), 64'h22);
    a = 10'h047;
    check_output("fresh_last_word", 64'((stamp[a] == run_id) ? mem[a] : MARK), 64'h88);

    // req_valid held through done: the second line is accepted in the IDLE
    // cycle right after DONE.
    run_id++;
    base_done   = done_count;
    base_accept = accept_count;
    apply_stimulus(32'h0000_0104, 0, 1'b0, 7, 99, 1'b1);
    @(posedge clk); #1;
    first_done = done_cyc;
    check_output("b2b_held_req", 64'(req_valid), 64'd1);
    apply_stimulus(32'h0000_02A8, 0, 1'b0, 7, 99, 1'b0);
    @(posedge clk); #1;
    check_output("b2b_accepts", 64'(accept_count - base_accept), 64'd2);
    check_output("b2b_accept_cycle", 64'(accept_cyc - first_done), 64'd1);
    check_output("b2b_done_count", 64'(done_count - base_done), 64'd2);
    check_output("b2b_resp", 64'(resp_seen), 64'h33);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
